// File: rtl/simd_pkg.sv
// Shared types and default widths for the SIMD activation writeback slice.
package simd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam int SIMD_LATENCY_SIGMOID = 3;
    localparam int SIMD_BIT_WIDTH       = 32;
    localparam int SIMD_ADDR_WIDTH      = 10;
    localparam int SIMD_CNT_WIDTH       = 16;

endpackage

// File: rtl/simd_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is visible on dout.
module simd_sync_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage is left unreset; the head is masked upstream when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/simd_act_writeback.sv
// Tags fixed-latency FU results with their address, buffers them and
// drains them to the scratchpad, with credit-based issue throttling.
module simd_act_writeback
    import simd_pkg::*;
#(
    parameter int BIT_WIDTH  = SIMD_BIT_WIDTH,
    parameter int ADDR_WIDTH = SIMD_ADDR_WIDTH,
    parameter int LATENCY    = SIMD_LATENCY_SIGMOID,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = SIMD_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_ops,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic [BIT_WIDTH-1:0]  fu_data_in,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BIT_WIDTH-1:0]  wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int FW = ADDR_WIDTH + BIT_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

    state_t state, state_nx;

    logic [CNT_WIDTH-1:0]  num_ops_q;
    logic [CNT_WIDTH-1:0]  issued_cnt;
    logic [CNT_WIDTH-1:0]  written_cnt;
    logic [CNT_WIDTH-1:0]  written_nx;
    logic [CW-1:0]         credits;
    logic [LATENCY-1:0]    tag_v;
    logic [ADDR_WIDTH-1:0] tag_a [LATENCY];

    logic          fire, pop, push;
    logic          busy_d, done_d;
    logic          f_full, f_empty;
    logic [CW-1:0] f_count;
    logic [FW-1:0] f_head;

    simd_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({tag_a[LATENCY-1], fu_data_in}),
        .pop   (pop),
        .dout  (f_head),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            num_ops_q   <= '0;
            issued_cnt  <= '0;
            written_cnt <= '0;
            credits     <= '0;
        end else begin
            state <= state_nx;
            busy  <= busy_d;
            done  <= done_d;
            if (state == IDLE && start) begin
                num_ops_q   <= num_ops;
                issued_cnt  <= '0;
                written_cnt <= '0;
            end else begin
                issued_cnt  <= issued_cnt + CNT_WIDTH'(fire);
                written_cnt <= written_nx;
            end
            credits <= credits + CW'(fire) - CW'(pop);
        end
    end

    // The last tag stage lines up with the FU result on fu_data_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) tag_a[i] <= '0;
        end else begin
            tag_v[0] <= fire;
            tag_a[0] <= issue_addr;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && num_ops != '0) state_nx = ISSUE;
            end
            ISSUE: begin
                if (issued_cnt + CNT_WIDTH'(fire) == num_ops_q)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (written_nx == num_ops_q) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issue_ready = (state == ISSUE) && (issued_cnt < num_ops_q)
                      && (credits < CRED_MAX);
        fire        = issue_valid && issue_ready;
        wr_valid    = !f_empty;
        pop         = wr_valid && wr_ready;
        push        = tag_v[LATENCY-1];
        written_nx  = written_cnt + CNT_WIDTH'(pop);
        wr_addr     = f_empty ? '0 : f_head[FW-1:BIT_WIDTH];
        wr_data     = f_empty ? '0 : f_head[BIT_WIDTH-1:0];
        busy_d      = (state_nx != IDLE);
        done_d      = (state == IDLE && start && num_ops == '0)
                      || (state == DRAIN && written_nx == num_ops_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && f_full && !pop));
            assert (f_count <= credits);
        end
    end

endmodule
